// File: rtl/mem_wb_if.sv
// MEM/WB stage bus: stage-4 results and hazard controls in, register-file write port out.
interface mem_wb_if #(
  parameter int unsigned Width = 32
);
  // Hazard controls and stage-4 results
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [Width-1:0] AdderResult;
  logic [Width-1:0] readData;
  logic [Width-1:0] Aluresult;
  logic [2:0]       controlsignal0;
  logic [4:0]       rd;

  // Write-back port, forwarding history and retirement counter
  logic [Width-1:0] wb_data;
  logic [4:0]       wb_rd;
  logic             wb_we;
  logic             wb_valid;
  logic [Width-1:0] prev_wb_data;
  logic [4:0]       prev_wb_rd;
  logic             prev_wb_we;
  logic [Width-1:0] retired_count;

  // Upstream side (memory stage / hazard unit / consumers)
  modport master (
    output stall, flush, in_valid, AdderResult, readData, Aluresult, controlsignal0, rd,
    input  wb_data, wb_rd, wb_we, wb_valid, prev_wb_data, prev_wb_rd, prev_wb_we,
           retired_count
  );

  // Stage side
  modport slave (
    input  stall, flush, in_valid, AdderResult, readData, Aluresult, controlsignal0, rd,
    output wb_data, wb_rd, wb_we, wb_valid, prev_wb_data, prev_wb_rd, prev_wb_we,
           retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, write-back select, last-write history and retire counter.
module mem_wb_stage #(
  parameter int unsigned Width = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_wb_if.slave  bus
);

  // ctrl bit positions
  localparam int unsigned CtrlRegWrite = 2;
  localparam int unsigned CtrlMemToReg = 1;
  localparam int unsigned CtrlLink     = 0;

  // Stage register
  logic             valid_q, valid_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [4:0]       rd_q, rd_d;
  logic [Width-1:0] link_q, link_d;
  logic [Width-1:0] mem_q, mem_d;
  logic [Width-1:0] alu_q, alu_d;

  // Retirement history
  logic [Width-1:0] prev_data_q, prev_data_d;
  logic [4:0]       prev_rd_q, prev_rd_d;
  logic             prev_we_q, prev_we_d;
  logic [Width-1:0] count_q, count_d;

  logic [Width-1:0] wb_data;
  logic             wb_we;
  logic             retire;

  // Write-back select and register-file enable from the stage register
  always_comb begin
    if (ctrl_q[CtrlLink]) begin
      wb_data = link_q;
    end else if (ctrl_q[CtrlMemToReg]) begin
      wb_data = mem_q;
    end else begin
      wb_data = alu_q;
    end
    // $0 is hardwired to zero, so writes to it are dropped here
    wb_we = valid_q & ctrl_q[CtrlRegWrite] & (rd_q != 5'd0);
  end

  // Next state: flush beats stall beats normal load; retirement ignores flush
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    link_d  = link_q;
    mem_d   = mem_q;
    alu_d   = alu_q;
    if (bus.flush) begin
      // Data fields are don't-care in a bubble; holding them saves toggles
      valid_d = 1'b0;
      ctrl_d  = 3'b000;
    end else if (!bus.stall) begin
      valid_d = bus.in_valid;
      ctrl_d  = bus.controlsignal0;
      rd_d    = bus.rd;
      link_d  = bus.AdderResult;
      mem_d   = bus.readData;
      alu_d   = bus.Aluresult;
    end

    // A flush on this edge kills the incoming entry, not the one leaving
    retire      = valid_q & ~bus.stall;
    prev_data_d = prev_data_q;
    prev_rd_d   = prev_rd_q;
    prev_we_d   = prev_we_q;
    count_d     = count_q;
    if (retire) begin
      prev_data_d = wb_data;
      prev_rd_d   = rd_q;
      prev_we_d   = wb_we;
      count_d     = count_q + Width'(1);
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= 3'b000;
      rd_q        <= 5'd0;
      link_q      <= '0;
      mem_q       <= '0;
      alu_q       <= '0;
      prev_data_q <= '0;
      prev_rd_q   <= 5'd0;
      prev_we_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      rd_q        <= rd_d;
      link_q      <= link_d;
      mem_q       <= mem_d;
      alu_q       <= alu_d;
      prev_data_q <= prev_data_d;
      prev_rd_q   <= prev_rd_d;
      prev_we_q   <= prev_we_d;
      count_q     <= count_d;
    end
  end

  // Drive the bus outputs
  always_comb begin
    bus.wb_data       = wb_data;
    bus.wb_rd         = rd_q;
    bus.wb_we         = wb_we;
    bus.wb_valid      = valid_q;
    bus.prev_wb_data  = prev_data_q;
    bus.prev_wb_rd    = prev_rd_q;
    bus.prev_wb_we    = prev_we_q;
    bus.retired_count = count_q;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, corner sequences, random vs model.
module tb_mem_wb_stage;

  logic clk;
  logic rst_n;

  mem_wb_if #(.Width(32)) bus ();
  mem_wb_if #(.Width(4))  bus4 ();

  mem_wb_stage #(.Width(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Narrow instance so counter wrap-around is reachable in a few cycles
  mem_wb_stage #(.Width(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // The staged instruction plus the list of everything that has retired so far.
  typedef struct {
    logic        valid;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] link, mem, alu;
  } entry_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } wr_t;

  entry_t m_stage;
  wr_t    m_retired[$];

  function automatic logic [31:0] m_wb_data(input entry_t e);
    // Link wins over load, load over ALU result
    return e.ctrl[0] ? e.link : (e.ctrl[1] ? e.mem : e.alu);
  endfunction

  function automatic logic m_wb_we(input entry_t e);
    return e.valid && e.ctrl[2] && e.rd != 0;
  endfunction

  task automatic model_reset();
    m_stage = '{valid: 1'b0, ctrl: 3'b0, rd: 5'd0, link: 32'd0, mem: 32'd0, alu: 32'd0};
    m_retired.delete();
  endtask

  task automatic model_edge();
    wr_t w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_stage.valid && !bus.stall) begin
      w.data = m_wb_data(m_stage);
      w.rd   = m_stage.rd;
      w.we   = m_wb_we(m_stage);
      m_retired.push_back(w);
    end
    if (bus.flush) begin
      m_stage.valid = 1'b0;
      m_stage.ctrl  = 3'b0;
    end else if (!bus.stall) begin
      m_stage.valid = bus.in_valid;
      m_stage.ctrl  = bus.controlsignal0;
      m_stage.rd    = bus.rd;
      m_stage.link  = bus.AdderResult;
      m_stage.mem   = bus.readData;
      m_stage.alu   = bus.Aluresult;
    end
  endtask

  task automatic check_model(input string tag);
    wr_t last;
    last = '{data: 32'd0, rd: 5'd0, we: 1'b0};
    if (m_retired.size() > 0) last = m_retired[$];
    check({tag, ".wb_data"},  bus.wb_data, m_wb_data(m_stage));
    check({tag, ".wb_rd"},    32'(bus.wb_rd), 32'(m_stage.rd));
    check({tag, ".wb_we"},    32'(bus.wb_we), 32'(m_wb_we(m_stage)));
    check({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'(m_stage.valid));
    check({tag, ".prev_data"}, bus.prev_wb_data, last.data);
    check({tag, ".prev_rd"},  32'(bus.prev_wb_rd), 32'(last.rd));
    check({tag, ".prev_we"},  32'(bus.prev_wb_we), 32'(last.we));
    check({tag, ".count"},    bus.retired_count, 32'(m_retired.size()));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".wb_data"},  bus.wb_data, 32'd0);
    check({tag, ".wb_rd"},    32'(bus.wb_rd), 32'd0);
    check({tag, ".wb_we"},    32'(bus.wb_we), 32'd0);
    check({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'd0);
    check({tag, ".prev_data"}, bus.prev_wb_data, 32'd0);
    check({tag, ".prev_rd"},  32'(bus.prev_wb_rd), 32'd0);
    check({tag, ".prev_we"},  32'(bus.prev_wb_we), 32'd0);
    check({tag, ".count"},    bus.retired_count, 32'd0);
  endtask

  // One rising edge; model follows, outputs settle, sampled 1 ns later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic iv, input logic [2:0] ctrl,
                       input logic [4:0] rd, input logic [31:0] adder,
                       input logic [31:0] rdata, input logic [31:0] alu);
    bus.stall          = st;
    bus.flush          = fl;
    bus.in_valid       = iv;
    bus.controlsignal0 = ctrl;
    bus.rd             = rd;
    bus.AdderResult    = adder;
    bus.readData       = rdata;
    bus.Aluresult      = alu;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        iv;
    logic [2:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] adder, rdata, alu;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_valid;
    logic [31:0] e_count;
    logic [4:0]  e_prev_rd;
    logic        e_prev_we;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] c0;

    vecs[0] = '{1, 3'b100, 5'd5,  32'h0, 32'h0, 32'h0000_1234,
                1, 5'd5,  32'h0000_1234, 1, 0, 5'd0, 0};
    vecs[1] = '{1, 3'b110, 5'd6,  32'h0, 32'hDEAD_BEEF, 32'h10,
                1, 5'd6,  32'hDEAD_BEEF, 1, 1, 5'd5, 1};
    vecs[2] = '{1, 3'b111, 5'd31, 32'h0040_0008, 32'h1, 32'h2,
                1, 5'd31, 32'h0040_0008, 1, 2, 5'd6, 1};
    vecs[3] = '{1, 3'b100, 5'd0,  32'h0, 32'h0, 32'hFFFF_FFFF,
                0, 5'd0,  32'hFFFF_FFFF, 1, 3, 5'd31, 1};
    vecs[4] = '{1, 3'b000, 5'd8,  32'h0, 32'h0, 32'h77,
                0, 5'd8,  32'h77, 1, 4, 5'd0, 0};
    vecs[5] = '{0, 3'b100, 5'd3,  32'h0, 32'h0, 32'h5,
                0, 5'd3,  32'h5, 0, 5, 5'd8, 0};
    vecs[6] = '{1, 3'b100, 5'd4,  32'h0, 32'h0, 32'h9,
                1, 5'd4,  32'h9, 1, 5, 5'd8, 0};

    model_reset();
    drive(0, 0, 0, 3'b000, 5'd0, 0, 0, 0);
    bus4.stall = 0; bus4.flush = 0; bus4.in_valid = 0; bus4.controlsignal0 = 3'b000;
    bus4.rd = 5'd0; bus4.AdderResult = 4'h0; bus4.readData = 4'h0; bus4.Aluresult = 4'h0;

    // Reset held for two edges, released mid-cycle
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_held");
    step();
    step();
    check_all_zero("reset_2edges");
    #3 rst_n = 1'b1;
    step();
    check_all_zero("after_release");

    // Table
    foreach (vecs[i]) begin
      drive(0, 0, vecs[i].iv, vecs[i].ctrl, vecs[i].rd, vecs[i].adder, vecs[i].rdata,
            vecs[i].alu);
      step();
      check($sformatf("vec%0d.wb_we", i),    32'(bus.wb_we), 32'(vecs[i].e_we));
      check($sformatf("vec%0d.wb_rd", i),    32'(bus.wb_rd), 32'(vecs[i].e_rd));
      check($sformatf("vec%0d.wb_data", i),  bus.wb_data, vecs[i].e_data);
      check($sformatf("vec%0d.wb_valid", i), 32'(bus.wb_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.count", i),    bus.retired_count, vecs[i].e_count);
      check($sformatf("vec%0d.prev_rd", i),  32'(bus.prev_wb_rd), 32'(vecs[i].e_prev_rd));
      check($sformatf("vec%0d.prev_we", i),  32'(bus.prev_wb_we), 32'(vecs[i].e_prev_we));
    end

    // Stall hold: rd7/0xAA held for three stalled edges while inputs move to rd9/0xBB
    drive(0, 0, 1, 3'b100, 5'd7, 0, 0, 32'hAA);
    step();
    c0 = bus.retired_count;
    check("stall.load_rd", 32'(bus.wb_rd), 32'd7);
    drive(1, 0, 1, 3'b100, 5'd9, 0, 0, 32'hBB);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall%0d.wb_rd", k),   32'(bus.wb_rd), 32'd7);
      check($sformatf("stall%0d.wb_data", k), bus.wb_data, 32'hAA);
      check($sformatf("stall%0d.wb_we", k),   32'(bus.wb_we), 32'd1);
      check($sformatf("stall%0d.count", k),   bus.retired_count, c0);
    end
    bus.stall = 1'b0;
    step();
    check("unstall.count",   bus.retired_count, c0 + 1);
    check("unstall.prev_rd", 32'(bus.prev_wb_rd), 32'd7);
    check("unstall.prev_data", bus.prev_wb_data, 32'hAA);
    check("unstall.wb_rd",   32'(bus.wb_rd), 32'd9);
    check("unstall.wb_data", bus.wb_data, 32'hBB);

    // Stall then stall+flush: the stalled entry is dropped without retiring
    bus.stall = 1'b1;
    step();
    c0 = bus.retired_count;
    check("stf.held_valid", 32'(bus.wb_valid), 32'd1);
    bus.flush = 1'b1;
    step();
    check("stf.wb_valid", 32'(bus.wb_valid), 32'd0);
    check("stf.wb_we",    32'(bus.wb_we), 32'd0);
    check("stf.count",    bus.retired_count, c0);

    // Flush alone on a retiring entry: it retires, a bubble follows
    drive(0, 0, 1, 3'b100, 5'd10, 0, 0, 32'h1010);
    step();
    check("fl.load_valid", 32'(bus.wb_valid), 32'd1);
    check("fl.load_count", bus.retired_count, c0);
    bus.flush = 1'b1;
    step();
    check("fl.count",    bus.retired_count, c0 + 1);
    check("fl.prev_rd",  32'(bus.prev_wb_rd), 32'd10);
    check("fl.wb_valid", 32'(bus.wb_valid), 32'd0);
    check("fl.wb_we",    32'(bus.wb_we), 32'd0);
    check_model("fl");

    // Async reset between edges while a write is pending
    drive(0, 0, 1, 3'b100, 5'd12, 0, 0, 32'h55);
    step();
    check("ar.pre_we", 32'(bus.wb_we), 32'd1);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("ar.immediate");
    step();
    check_all_zero("ar.held_edge");
    #3 rst_n = 1'b1;
    drive(0, 0, 0, 3'b000, 5'd0, 0, 0, 0);
    step();
    check_all_zero("ar.release");

    // Counter wrap on the 4-bit instance: 16 retirements bring it back to 0
    bus4.in_valid = 1'b1;
    bus4.controlsignal0 = 3'b100;
    bus4.rd = 5'd3;
    bus4.Aluresult = 4'hA;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 1) check("w4.wb_data", 32'(bus4.wb_data), 32'hA);
      if (k == 16) check("w4.count_max", 32'(bus4.retired_count), 32'd15);
      if (k == 17) check("w4.count_wrap", 32'(bus4.retired_count), 32'd0);
    end
    bus4.in_valid = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0), 1'($urandom),
            3'($urandom), ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom, $urandom);
      step();
      check_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Pipeline register plus write-back stage that sits directly downstream of the memory-access stage (stage 4) in the 5-stage MIPS datapath. It latches the memory stage's results, which are the PC+4/link value, the load data, the ALU result, the 3-bit WB control and the destination register. It then selects the register-file write value and drives the register-file write port. It also provides a one-entry history of the last retired write for EX-stage forwarding, and a retired-instruction counter.

Parameters:
Width, 32, datapath width of all data fields and of the retired-instruction counter.

Ports:
clk  input  1  pipeline clock; all state updates on rising edge.
rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
stall  input  1  hold the stage register (hazard unit).
flush  input  1  replace the incoming entry with a bubble.
in_valid  input  1  stage-4 entry carries a real instruction.
AdderResult  input  Width  PC+4 from stage 4, used as the link value.
readData  input  Width  data-memory read value from stage 4.
Aluresult  input  Width  ALU result from stage 4.
controlsignal0  input  3  [2]=RegWrite, [1]=MemtoReg, [0]=Link.
rd  input  5  destination register from stage 4.
wb_data  output  Width  register-file write data.
wb_rd  output  5  register-file write address.
wb_we  output  1  register-file write enable.
wb_valid  output  1  stage register holds a real instruction.
prev_wb_data  output  Width  data of the last retired write.
prev_wb_rd  output  5  address of the last retired write.
prev_wb_we  output  1  enable of the last retired write.
retired_count  output  Width  number of retired instructions.

Behaviour:
- Stage register fields: valid, ctrl[2:0], rd[4:0], link, mem, alu.
- Reset (rst_n=0, asynchronous): all fields, prev_* and retired_count are cleared to 0. All outputs read 0 while reset is held and on the first edge after release.
- Priority at each rising edge is flush > stall > normal load.
- flush=1: valid<=0 and ctrl<=0. Data fields are don't-care and are held. Flush overrides a simultaneous stall.
- stall=1 (no flush): every field holds its value. wb_we stays asserted if it was asserted; rewriting the same value to the same register is idempotent and required.
- Normal load: valid<=in_valid. ctrl, rd and the data fields are loaded from the inputs.
- Latency: stage-4 outputs present at edge N appear on wb_* after edge N. No further cycles of delay.
- Write-back mux (combinational from the register):
  - ctrl[0]=1: wb_data=link.
  - else ctrl[1]=1: wb_data=mem.
  - else: wb_data=alu.
  - Link has priority over MemtoReg.
- wb_rd = registered rd.
- wb_we = valid & ctrl[2] & (rd != 0). Writes to $0 are always suppressed, but wb_data and wb_rd are still driven.
- wb_valid = valid.
- Retirement event: valid=1 and stall=0 at a rising edge, regardless of flush. A flush on that edge kills the incoming entry, not the retiring one.
- On a retirement event:
  - prev_wb_data, prev_wb_rd and prev_wb_we take the current wb_data, wb_rd and wb_we.
  - retired_count increments by 1, wrapping modulo 2^Width.
- With no retirement event, prev_* and retired_count hold.
- Bubbles (valid=0) never retire, never assert wb_we and never update prev_*.
- Reset asserted mid-stall or mid-flush clears state immediately. No partial write is produced after reset asserts.

Test Plan:
- Reset then ALU op: rst_n low 2 cycles, release, then present in_valid=1, ctrl=3'b100, rd=5, Aluresult=0x0000_1234. Required after next edge: wb_we=1, wb_rd=5, wb_data=0x1234. Required on the following edge: retired_count=1, prev_wb_rd=5.
- Load vs link select:
  - ctrl=3'b110, readData=0xDEADBEEF, Aluresult=0x10 → wb_data=0xDEADBEEF.
  - ctrl=3'b111, AdderResult=0x0040_0008 → wb_data=0x0040_0008 (link wins).
- $0 suppression: ctrl=3'b100, rd=0, Aluresult=0xFFFF_FFFF → wb_we=0 and wb_data=0xFFFF_FFFF. retired_count still increments; prev_wb_we=0.
- Stall hold: load the entry rd=7/0xAA, then assert stall for 3 cycles while the inputs change to rd=9/0xBB. Required: wb_rd=7, wb_data=0xAA and wb_we=1 throughout, with retired_count unchanged. Required after stall drops: one increment, prev_wb_rd=7, then wb_rd=9.
- Flush and simultaneous stall+flush:
  - Valid entry held by stall, then stall=1 and flush=1 together: wb_valid=0 and wb_we=0 next cycle, with no retirement counted for the stalled entry.
  - Flush alone on a retiring entry: that entry retires (count+1), then a bubble follows.
- Async reset mid-operation: with wb_we=1 and retired_count=0x5, drop rst_n between clock edges. Required immediately, without waiting for an edge: all outputs 0. Separately, force retired_count=2^Width-1 and retire one instruction → 0.
